// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive-side buffer.
package uart_pkg;

  localparam int unsigned UART_DATA_W = 8;
  localparam int unsigned DROP_CNT_W  = 8;

  typedef enum logic [1:0] {
    WAIT = 2'b00,
    CLR  = 2'b01,
    HOLD = 2'b10
  } rx_state_t;

  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (v == '1) ? v : v + {{(DROP_CNT_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/uart_rx_buffer_sync_fifo.sv
// First-word-fall-through synchronous FIFO with registered level/full/valid.
module sync_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = UART_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_wr_en,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_wr_accept,
  input  logic              i_rd_en,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_valid,
  output logic              o_full,
  output logic [ADDR_W:0]   o_level
);

  localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W:0]   r_wr_ptr;
  logic [ADDR_W:0]   r_rd_ptr;
  logic [ADDR_W:0]   r_level;
  logic              r_full;
  logic              r_valid;

  logic              w_push;
  logic              w_pop;
  logic [ADDR_W:0]   w_wr_ptr_nxt;
  logic [ADDR_W:0]   w_rd_ptr_nxt;

  // A full FIFO still accepts a write when a pop frees the head slot on the same edge.
  assign w_pop        = i_rd_en & r_valid;
  assign w_push       = i_wr_en & (~r_full | w_pop);
  assign w_wr_ptr_nxt = w_push ? r_wr_ptr + PTR_ONE : r_wr_ptr;
  assign w_rd_ptr_nxt = w_pop  ? r_rd_ptr + PTR_ONE : r_rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_full   <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      r_wr_ptr <= w_wr_ptr_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      r_level  <= w_wr_ptr_nxt - w_rd_ptr_nxt;
      r_full   <= (w_wr_ptr_nxt[ADDR_W] != w_rd_ptr_nxt[ADDR_W]) &&
                  (w_wr_ptr_nxt[ADDR_W-1:0] == w_rd_ptr_nxt[ADDR_W-1:0]);
      r_valid  <= (w_wr_ptr_nxt != w_rd_ptr_nxt);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[ADDR_W-1:0]] <= i_wr_data;
    end
  end

  assign o_wr_accept = w_push;
  assign o_rd_data   = r_mem[r_rd_ptr[ADDR_W-1:0]];
  assign o_rd_valid  = r_valid;
  assign o_full      = r_full;
  assign o_level     = r_level;

endmodule

// File: rtl/uart_rx_buffer.sv
// Captures UART receiver bytes into a FIFO with handshake and sticky overrun.
// Optional dropped-byte counter enabled by defining UART_RX_BUF_DROP_CNT_EN.
module uart_rx_buffer
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic                   clk_50mhz,
  input  logic                   rst_n,
  input  logic                   uart_ready,
  input  logic [UART_DATA_W-1:0] uart_data,
  output logic                   uart_ready_clr,
  input  logic                   rd_en,
  output logic [UART_DATA_W-1:0] rd_data,
  output logic                   rd_valid,
  output logic                   full,
  output logic [ADDR_W:0]        level,
  output logic                   overrun,
  input  logic                   overrun_clr
`ifdef UART_RX_BUF_DROP_CNT_EN
  ,
  output logic [DROP_CNT_W-1:0]  drop_cnt
`endif
);

  rx_state_t r_state;
  rx_state_t w_state_nxt;
  logic      w_capture;
  logic      w_wr_accept;
  logic      w_drop;
  logic      r_ready_clr;
  logic      r_overrun;

  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= WAIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    case (r_state)
      WAIT: begin
        if (uart_ready) begin
          w_capture   = 1'b1;
          w_state_nxt = CLR;
        end
      end
      CLR:  w_state_nxt = HOLD;
      HOLD: begin
        if (!uart_ready) begin
          w_state_nxt = WAIT;
        end
      end
      default: w_state_nxt = WAIT;
    endcase
  end

  // Acknowledge is flopped from the next state so it is glitch-free and high only while in CLR.
  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_ready_clr <= 1'b0;
    end else begin
      r_ready_clr <= (w_state_nxt == CLR);
    end
  end

  sync_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (UART_DATA_W)
  ) u_fifo (
    .clk         (clk_50mhz),
    .rst_n       (rst_n),
    .i_wr_en     (w_capture),
    .i_wr_data   (uart_data),
    .o_wr_accept (w_wr_accept),
    .i_rd_en     (rd_en),
    .o_rd_data   (rd_data),
    .o_rd_valid  (rd_valid),
    .o_full      (full),
    .o_level     (level)
  );

  assign w_drop = w_capture & ~w_wr_accept;

  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_overrun <= 1'b0;
    end else if (w_drop) begin
      r_overrun <= 1'b1;
    end else if (overrun_clr) begin
      r_overrun <= 1'b0;
    end
  end

`ifdef UART_RX_BUF_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] r_drop_cnt;

  // A drop coinciding with a clear restarts the count at one.
  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_drop_cnt <= overrun_clr ? {{(DROP_CNT_W-1){1'b0}}, 1'b1} : sat_inc(r_drop_cnt);
    end else if (overrun_clr) begin
      r_drop_cnt <= '0;
    end
  end

  assign drop_cnt = r_drop_cnt;
`endif

  assign uart_ready_clr = r_ready_clr;
  assign overrun        = r_overrun;

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Self-checking bench for uart_rx_buffer against a transaction-level queue model.
module tb_uart_rx_buffer;

  localparam int DEPTH = 16;

  logic       clk_50mhz = 1'b0;
  logic       rst_n;
  logic       uart_ready;
  logic [7:0] uart_data;
  logic       uart_ready_clr;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       full;
  logic [4:0] level;
  logic       overrun;
  logic       overrun_clr;
`ifdef UART_RX_BUF_DROP_CNT_EN
  logic [7:0] drop_cnt;
`endif

  uart_rx_buffer #(
    .DEPTH  (16),
    .ADDR_W (4)
  ) dut (
    .clk_50mhz      (clk_50mhz),
    .rst_n          (rst_n),
    .uart_ready     (uart_ready),
    .uart_data      (uart_data),
    .uart_ready_clr (uart_ready_clr),
    .rd_en          (rd_en),
    .rd_data        (rd_data),
    .rd_valid       (rd_valid),
    .full           (full),
    .level          (level),
    .overrun        (overrun),
    .overrun_clr    (overrun_clr)
`ifdef UART_RX_BUF_DROP_CNT_EN
    ,
    .drop_cnt       (drop_cnt)
`endif
  );

  always #10 clk_50mhz = ~clk_50mhz;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] q[$];
  bit         ovr;
  int         cnt;

  task automatic tick();
    @(posedge clk_50mhz);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, ":level"},    32'(level),    32'(q.size()));
    chk({tag, ":rd_valid"}, 32'(rd_valid), 32'(q.size() > 0));
    chk({tag, ":full"},     32'(full),     32'(q.size() == DEPTH));
    chk({tag, ":overrun"},  32'(overrun),  32'(ovr));
    if (q.size() > 0) chk({tag, ":rd_data"}, 32'(rd_data), 32'(q[0]));
`ifdef UART_RX_BUF_DROP_CNT_EN
    chk({tag, ":drop_cnt"}, 32'(drop_cnt), 32'(cnt));
`endif
  endtask

  // One receiver frame: raise ready, optionally pop/clear on the capture edge,
  // keep ready high for `hold` extra cycles, then release it.
  task automatic send(input logic [7:0] b, input bit pop, input bit oclr, input int hold);
    bit do_pop;
    bit acc;
    int pulses;
    chk("idle_clr", 32'(uart_ready_clr), 32'd0);
    uart_data   = b;
    uart_ready  = 1'b1;
    rd_en       = pop;
    overrun_clr = oclr;
    do_pop = pop && (q.size() > 0);
    acc    = (q.size() < DEPTH) || do_pop;
    tick();
    rd_en       = 1'b0;
    overrun_clr = 1'b0;
    if (do_pop) void'(q.pop_front());
    if (acc) begin
      q.push_back(b);
      if (oclr) begin
        ovr = 1'b0;
        cnt = 0;
      end
    end else begin
      ovr = 1'b1;
      cnt = oclr ? 1 : ((cnt < 255) ? cnt + 1 : 255);
    end
    chk("clr_pulse", 32'(uart_ready_clr), 32'd1);
    check_state("capture");
    pulses = 1;
    for (int i = 0; i < hold + 1; i++) begin
      tick();
      if (uart_ready_clr) pulses++;
    end
    chk("one_pulse", 32'(pulses), 32'd1);
    check_state("hold");
    uart_ready = 1'b0;
    tick();
    chk("release_clr", 32'(uart_ready_clr), 32'd0);
  endtask

  task automatic pop();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    if (q.size() > 0) void'(q.pop_front());
    check_state("pop");
  endtask

  task automatic clear_ovr();
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    ovr = 1'b0;
    cnt = 0;
    check_state("ovr_clr");
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n       = 1'b0;
    uart_ready  = 1'b0;
    uart_data   = '0;
    rd_en       = 1'b0;
    overrun_clr = 1'b0;
    ovr         = 1'b0;
    cnt         = 0;
    #15;
    chk("rst_clr", 32'(uart_ready_clr), 32'd0);
    check_state("reset");
    @(negedge clk_50mhz);
    rst_n = 1'b1;
    tick();
    check_state("post_reset");

    // Single byte, then pop it, then pop while empty.
    send(8'hA5, 1'b0, 1'b0, 0);
    pop();
    pop();

    // Receiver flag stays high for 10 cycles after the acknowledge.
    send(8'h3C, 1'b0, 1'b0, 10);
    pop();

    // Fill, overflow by one, drain.
    for (int i = 0; i < 16; i++) send(8'(i), 1'b0, 1'b0, 0);
    send(8'hFF, 1'b0, 1'b0, 0);
    for (int i = 0; i < 16; i++) pop();

    // Push and pop on the same edge while full.
    clear_ovr();
    for (int i = 0; i < 16; i++) send(8'($urandom_range(0, 255)), 1'b0, 1'b0, 0);
    send(8'h42, 1'b1, 1'b0, 0);
    for (int i = 0; i < 16; i++) pop();

    // Drop coinciding with overrun_clr, then many drops to saturate the count.
    for (int i = 0; i < 16; i++) send(8'($urandom_range(0, 255)), 1'b0, 1'b0, 0);
    send(8'h77, 1'b0, 1'b1, 0);
    for (int i = 0; i < 300; i++) send(8'($urandom_range(0, 255)), 1'b0, 1'b0, 0);

    // Asynchronous reset while the acknowledge is high.
    for (int i = 0; i < 12; i++) pop();
    uart_data  = 8'h5A;
    uart_ready = 1'b1;
    tick();
    q.push_back(8'h5A);
    chk("pre_rst_clr", 32'(uart_ready_clr), 32'd1);
    check_state("pre_rst");
    #3;
    rst_n = 1'b0;
    uart_ready = 1'b0;
    #1;
    q.delete();
    ovr = 1'b0;
    cnt = 0;
    chk("async_rst_clr", 32'(uart_ready_clr), 32'd0);
    check_state("async_rst");
    @(negedge clk_50mhz);
    rst_n = 1'b1;
    tick();
    check_state("rst_release");
    send(8'hC3, 1'b0, 1'b0, 0);
    pop();

    // Randomized mix of frames, pops and clears.
    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 5))
        0, 1, 2: send(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 3) == 0), int'($urandom_range(0, 2)));
        3, 4:    pop();
        default: clear_ovr();
      endcase
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_buffer.md
Name: uart_rx_buffer

Overview:
- Downstream consumer of the UART receiver; sits between the top-level uart's ready/ready_clr/data_out and the host logic.
- Captures each received byte, acknowledges the receiver with a single-cycle ready_clr pulse, and stores the byte in a FIFO.
- The host drains the FIFO through a first-word-fall-through pop interface, so back-to-back frames are not lost while the host is busy.

Parameters:
- DEPTH, 16, FIFO entries; must be a power of 2 and at least 2.
- ADDR_W, 4, equals log2(DEPTH); pointers are ADDR_W+1 bits wide.

Ports:
- clk_50mhz  input  1  system clock, all logic on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- uart_ready  input  1  receiver byte-available flag (uart.ready).
- uart_data  input  8  receiver byte (uart.data_out).
- uart_ready_clr  output  1  acknowledge to receiver (uart.ready_clr), registered.
- rd_en  input  1  host pop request.
- rd_data  output  8  head-of-FIFO byte; valid when rd_valid=1.
- rd_valid  output  1  FIFO not empty.
- full  output  1  FIFO holds DEPTH entries.
- level  output  ADDR_W+1  current entry count, 0..DEPTH.
- overrun  output  1  sticky flag: a byte was dropped because the FIFO was full.
- overrun_clr  input  1  clears overrun.

Behaviour:
- Reset (async assert, sync release): FSM=WAIT, pointers=0, level=0, rd_valid=0, full=0, overrun=0, uart_ready_clr=0. FIFO memory is not reset; rd_data is don't-care while rd_valid=0.
- Capture FSM (Moore):
  - WAIT: uart_ready=1 at an edge -> push uart_data (or drop it, see overrun) and go to CLR.
  - CLR: uart_ready_clr=1 for exactly one cycle, then go to HOLD.
  - HOLD: stay until uart_ready=0, then go to WAIT. This prevents recapturing the same byte while the receiver's flag decays.
- uart_ready_clr is high only in CLR; it is never held high across cycles.
- Push accepted when full=0, or when full=1 and a valid pop (rd_en & rd_valid) occurs on the same edge.
- Latency: the byte appears on rd_data with rd_valid=1 on the cycle after the capture edge, if the FIFO was empty.
- Pop: at an edge with rd_en=1 and rd_valid=1, rd_ptr advances. rd_en while empty is ignored and nothing changes.
- Simultaneous push and pop: level unchanged, both pointers advance. This also holds at full and at level 1.
- Pointers wrap modulo 2*DEPTH:
  - empty when ptrs are equal;
  - full when the MSBs differ and the lower ADDR_W bits are equal.
- level, full and rd_valid are registered and update on the same edge as the pointers.
- Overrun:
  - A byte arriving when the push is not accepted is discarded, overrun is set, and the FSM still goes to CLR so the receiver is released.
  - When a set and overrun_clr occur on the same edge, set wins.
- Reset mid-frame or mid-handshake returns the FSM to WAIT. If uart_ready is still high after reset, that byte is captured once; this is accepted behaviour.

Optional Feature:
- Macro UART_RX_BUF_DROP_CNT_EN.
- Defined: adds output port drop_cnt [7:0]. It counts dropped bytes, saturates at 255, is reset to 0 by rst_n, and is cleared by overrun_clr. If an increment and a clear occur on the same edge, the result is 1.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Decomposition:
- Package uart_pkg holds:
  - UART_DATA_W=8;
  - the FSM state typedef (WAIT, CLR, HOLD; 2-bit encoding 00/01/10);
  - DROP_CNT_W=8.
- Sub-module sync_fifo (DEPTH, ADDR_W, data width 8) holds pointers, memory, level, full and rd_valid.
- uart_rx_buffer holds the FSM, overrun logic and the optional counter.

Test Plan:
- Single byte: hold uart_ready=1 with uart_data=8'hA5 until the pulse, then drop it -> exactly one uart_ready_clr pulse; rd_valid=1 with rd_data=8'hA5 on the next cycle; level=1. rd_en for 1 cycle -> rd_valid=0, level=0.
- Sticky ready: hold uart_ready=1 for 10 cycles after CLR -> FSM stays in HOLD, level stays 1, only one ready_clr pulse.
- Fill and overrun: push 16 bytes 8'h00..8'h0F with no pops -> full=1, level=16. 17th byte 8'hFF -> dropped, overrun=1, ready_clr still pulses. Drain -> reads 00..0F in order, 8'hFF never seen.
- Push and pop on the same edge at full: full FIFO, rd_en=1 on the capture edge of 8'h42 -> level stays 16, overrun stays 0, 8'h42 is read last.
- Overrun set and clear on the same edge -> overrun=1. With UART_RX_BUF_DROP_CNT_EN defined -> drop_cnt=1. After 300 drops -> drop_cnt=255.
- Async reset asserted in CLR with level=5 -> immediately uart_ready_clr=0, level=0, rd_valid=0, overrun=0. After release, FSM is in WAIT.
